hilo_accumulate_unit: RTL
=========================

Name: hilo_accumulate_unit

Overview:
Holds the architectural HI/LO registers. Consumes the 64-bit result of the execution stage: ALU_out as the low word and ALU_hi as the high word. Supports plain writes, MADD/MSUB 64-bit accumulate, MTHI/MTLO and MFHI/MFLO. The accumulate is split over two cycles to keep the 64-bit carry chain off the critical path, and the unit stalls the issuing pipeline stage while the accumulate completes.

Parameters:
WIDTH, 32, width of HI, LO and all data ports

Ports:
Clk  input  1  clock; all state updates on rising edge
Rst  input  1  reset; synchronous, active-low
Valid  input  1  HiLoOp is valid this cycle
HiLoOp  input  3  000 NOP, 001 WRITE, 010 MADD, 011 MSUB, 100 MTHI, 101 MTLO, 110 MFHI, 111 MFLO
Lo_in  input  WIDTH  low word of execution result (ALU_out)
Hi_in  input  WIDTH  high word of execution result (ALU_hi)
Rs_in  input  WIDTH  source operand for MTHI/MTLO
Stall_out  output  1  op presented this cycle not accepted; upstream holds it
Busy  output  1  accumulate high half in progress
Hi_out  output  WIDTH  current HI register
Lo_out  output  WIDTH  current LO register
MfData  output  WIDTH  read data for MFHI/MFLO

Behaviour:
- Reset (Rst==0 at rising edge): HI=0, LO=0, carry=0, held high word=0, sign=0, state=IDLE.
- Reset dominates any op. Reset during ACC_HI abandons the accumulate.
- Outputs after reset: Busy=0, Hi_out=Lo_out=0. Stall_out and MfData are combinational. MfData=0 unless an accepted MF op is present.
- "Accepted" means Valid && HiLoOp!=NOP && Stall_out==0.
- FSM has two states: IDLE and ACC_HI.
- IDLE, accepted op:
  - WRITE: HI<=Hi_in, LO<=Lo_in. Visible on Hi_out/Lo_out the next cycle.
  - MTHI: HI<=Rs_in, LO unchanged.
  - MTLO: LO<=Rs_in, HI unchanged.
  - MFHI: MfData=HI combinationally, same cycle. No state change.
  - MFLO: MfData=LO combinationally, same cycle. No state change.
  - MADD: {c,LO}<=LO+Lo_in (33-bit sum, carry into c). Latch Hi_in and sign=0. Go to ACC_HI.
  - MSUB: {b,LO}<=LO-Lo_in (borrow into c). Latch Hi_in and sign=1. Go to ACC_HI.
- ACC_HI (exactly one cycle):
  - Busy=1.
  - sign=0: HI<=HI+held+c. sign=1: HI<=HI-held-c.
  - c<=0, return to IDLE.
  - Any Valid op other than NOP: Stall_out=1, op ignored, no state change from it. This applies to every op, including MFLO.
  - Valid==0 or NOP: Stall_out=0.
- Total accumulate latency: 2 cycles from acceptance to final HI/LO.
  - LO is updated after cycle 1. HI is updated after cycle 2.
  - Back-to-back MADD incurs exactly one stall cycle.
- Arithmetic is modulo 2^64 across {HI,LO}. No overflow flag, no trap.
- Valid==0: HiLoOp is ignored and Stall_out=0.
- Stall_out is never asserted in IDLE.
- Upstream must keep Valid, HiLoOp and operands stable while Stall_out=1.
- Inputs on the cycle the op is accepted are the only ones used. Hi_in is latched, so a change during ACC_HI has no effect.

Test Plan:
- Reset then hold: Rst=0 for 2 cycles, then Valid=1 MFHI and MFLO -> HI=LO=0, MfData=0, Stall_out=0, Busy=0.
- WRITE Hi_in=0x00000000, Lo_in=0xFFFFFFFF; then MADD Hi_in=0, Lo_in=1 -> LO=0 after cycle 1, Busy=1 in cycle 2, HI=0x00000001 after cycle 2.
- WRITE HI=1, LO=0; MSUB Hi_in=0, Lo_in=1; MFHI presented in the next cycle -> Stall_out=1 for one cycle, then MfData=0x00000000. Final LO=0xFFFFFFFF.
- MTHI Rs_in=0xDEADBEEF, MTLO Rs_in=0x12345678, then MFHI and MFLO -> MfData=0xDEADBEEF then 0x12345678; Hi_out/Lo_out match.
- Back-to-back MADD: WRITE {0,5}; MADD {1,0xFFFFFFFF}; MADD {0,2} held through stall -> one stall cycle, final HI=0x00000002, LO=0x00000006.
- Reset mid-accumulate: MADD accepted, Rst=0 during ACC_HI -> next cycle HI=LO=0, Busy=0, state IDLE, and a following MFHI is accepted without stall.

Source files
------------

// File: rtl/hilo_accumulate_unit_if.sv
// Issue/response bundle between the execution stage and the HI/LO unit.
// The clock and reset stay plain module ports and are not part of this interface.
interface hilo_accumulate_unit_if #(parameter int WIDTH = 32);
  logic             Valid;
  logic [2:0]       HiLoOp;
  logic [WIDTH-1:0] Lo_in;
  logic [WIDTH-1:0] Hi_in;
  logic [WIDTH-1:0] Rs_in;
  logic             Stall_out;
  logic             Busy;
  logic [WIDTH-1:0] Hi_out;
  logic [WIDTH-1:0] Lo_out;
  logic [WIDTH-1:0] MfData;

  modport master (
    output Valid, HiLoOp, Lo_in, Hi_in, Rs_in,
    input  Stall_out, Busy, Hi_out, Lo_out, MfData
  );

  modport slave (
    input  Valid, HiLoOp, Lo_in, Hi_in, Rs_in,
    output Stall_out, Busy, Hi_out, Lo_out, MfData
  );
endinterface

// File: rtl/hilo_accumulate_unit.sv
// HI/LO register pair with a 64-bit MADD/MSUB accumulate.
// The low half is computed in the first cycle and the high half in the second.
module hilo_accumulate_unit #(
  parameter int WIDTH = 32
) (
  input  logic                  Clk,
  input  logic                  Rst,
  hilo_accumulate_unit_if.slave bus
);

  typedef enum logic [2:0] {
    OP_NOP   = 3'b000,
    OP_WRITE = 3'b001,
    OP_MADD  = 3'b010,
    OP_MSUB  = 3'b011,
    OP_MTHI  = 3'b100,
    OP_MTLO  = 3'b101,
    OP_MFHI  = 3'b110,
    OP_MFLO  = 3'b111
  } op_t;

  typedef enum logic {IDLE, ACC_HI} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] hi_q, lo_q, held_q;
  logic             c_q, sign_q;

  op_t              op;
  logic             op_vld, accept, stall;
  logic [WIDTH-1:0] mf_data;
  logic [WIDTH:0]   lo_add, lo_sub;
  logic [WIDTH-1:0] c_ext, hi_acc;

  assign op     = op_t'(bus.HiLoOp);
  assign op_vld = bus.Valid && (op != OP_NOP);
  assign accept = op_vld && !stall;

  // Bit WIDTH is the carry for the add and the borrow for the subtract.
  assign lo_add = {1'b0, lo_q} + {1'b0, bus.Lo_in};
  assign lo_sub = {1'b0, lo_q} - {1'b0, bus.Lo_in};
  assign c_ext  = {{(WIDTH-1){1'b0}}, c_q};
  assign hi_acc = sign_q ? (hi_q - held_q - c_ext) : (hi_q + held_q + c_ext);

  always_comb begin
    state_nx = state;
    stall    = 1'b0;
    mf_data  = '0;
    case (state)
      IDLE: begin
        if (op_vld) begin
          case (op)
            OP_MADD, OP_MSUB: state_nx = ACC_HI;
            OP_MFHI:          mf_data  = hi_q;
            OP_MFLO:          mf_data  = lo_q;
            default:          ;
          endcase
        end
      end
      ACC_HI: begin
        stall    = op_vld;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state  <= IDLE;
      hi_q   <= '0;
      lo_q   <= '0;
      held_q <= '0;
      c_q    <= 1'b0;
      sign_q <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == ACC_HI) begin
        hi_q <= hi_acc;
        c_q  <= 1'b0;
      end else if (accept) begin
        case (op)
          OP_WRITE: begin
            hi_q <= bus.Hi_in;
            lo_q <= bus.Lo_in;
          end
          OP_MADD: begin
            {c_q, lo_q} <= lo_add;
            held_q      <= bus.Hi_in;
            sign_q      <= 1'b0;
          end
          OP_MSUB: begin
            {c_q, lo_q} <= lo_sub;
            held_q      <= bus.Hi_in;
            sign_q      <= 1'b1;
          end
          OP_MTHI: hi_q <= bus.Rs_in;
          OP_MTLO: lo_q <= bus.Rs_in;
          default: ;
        endcase
      end
    end
  end

  assign bus.Stall_out = stall;
  assign bus.Busy      = (state == ACC_HI);
  assign bus.Hi_out    = hi_q;
  assign bus.Lo_out    = lo_q;
  assign bus.MfData    = mf_data;

endmodule
